// File: rtl/mem_stage_if.sv
// Data-memory bus between the memory stage (master) and the data memory (slave).
// Request side is driven by the master and held stable until dmem_ready is seen;
// dmem_rdata is only meaningful in a cycle where dmem_ready is high.
interface mem_stage_if #(
    parameter int ADDR_W = 64
);
    logic              dmem_req;
    logic              dmem_we;
    logic [ADDR_W-1:0] dmem_addr;
    logic [63:0]       dmem_wdata;
    logic [7:0]        dmem_be;
    logic              dmem_ready;
    logic [63:0]       dmem_rdata;

    modport master (
        output dmem_req,
        output dmem_we,
        output dmem_addr,
        output dmem_wdata,
        output dmem_be,
        input  dmem_ready,
        input  dmem_rdata
    );

    modport slave (
        input  dmem_req,
        input  dmem_we,
        input  dmem_addr,
        input  dmem_wdata,
        input  dmem_be,
        output dmem_ready,
        output dmem_rdata
    );
endinterface

// File: rtl/mem_stage.sv
// Memory-stage access unit of the RV64I pipeline.
// Turns a load/store in M into one request/ready transaction on the data bus,
// builds byte enables and store lanes, and aligns/extends returned load data.
// Upstream stages are frozen (StallMem_M) until the access finishes, and the
// register write towards MW is held off while stalled.
// Optional feature: define MEM_MISALIGN_TRAP_EN to flag misaligned accesses
// (Misaligned_M) instead of silently aligning them down.
module mem_stage #(
    parameter int ADDR_W = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [63:0] ALUResult_M,
    input  logic [63:0] WriteData_M,
    input  logic [2:0]  Funct3_M,
    input  logic        MemWrite_M,
    input  logic [1:0]  ResultSrc_M,
    input  logic        RegWrite_M,
    output logic [63:0] ReadData_M,
    output logic        RegWriteOut_M,
    output logic        StallMem_M,
    output logic        Misaligned_M,
    mem_stage_if.master dmem
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic              req_q, req_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [63:0]       wdata_q, wdata_d;
    logic [7:0]        be_q, be_d;
    logic [2:0]        f3_q, f3_d;
    logic [2:0]        off_q, off_d;
    logic [63:0]       data_q, data_d;

    logic              access;
    logic              start;
    logic              trap;
    logic [2:0]        align_mask;
    logic [2:0]        off_eff;
    logic [7:0]        be_base;
    logic [63:0]       rdata_shifted;
    logic [63:0]       load_ext;

    assign access = MemWrite_M | (ResultSrc_M == 2'b01);

    // Byte mask of the access size and the offset bits that must stay for it
    // (funct3 111 falls into the doubleword case)
    always_comb begin
        be_base    = 8'hFF;
        align_mask = 3'b000;
        case (Funct3_M[1:0])
            2'b00: begin
                be_base    = 8'h01;
                align_mask = 3'b111;
            end
            2'b01: begin
                be_base    = 8'h03;
                align_mask = 3'b110;
            end
            2'b10: begin
                be_base    = 8'h0F;
                align_mask = 3'b100;
            end
            default: begin
                be_base    = 8'hFF;
                align_mask = 3'b000;
            end
        endcase
    end

    assign off_eff = ALUResult_M[2:0] & align_mask;

`ifdef MEM_MISALIGN_TRAP_EN
    assign trap = (state_q == IDLE) && access
                  && ((ALUResult_M[2:0] & ~align_mask) != 3'b000);
`else
    assign trap = 1'b0;
`endif

    assign Misaligned_M  = trap;
    assign start         = (state_q == IDLE) && access && !trap;
    assign StallMem_M    = start || (state_q == REQ);
    assign RegWriteOut_M = RegWrite_M && !StallMem_M && !trap;

    // Align the returned doubleword to the latched offset and extend it
    always_comb begin
        rdata_shifted = dmem.dmem_rdata >> {off_q, 3'b000};
        load_ext      = rdata_shifted;
        case (f3_q)
            3'b000:  load_ext = {{56{rdata_shifted[7]}},  rdata_shifted[7:0]};
            3'b001:  load_ext = {{48{rdata_shifted[15]}}, rdata_shifted[15:0]};
            3'b010:  load_ext = {{32{rdata_shifted[31]}}, rdata_shifted[31:0]};
            3'b100:  load_ext = {56'd0, rdata_shifted[7:0]};
            3'b101:  load_ext = {48'd0, rdata_shifted[15:0]};
            3'b110:  load_ext = {32'd0, rdata_shifted[31:0]};
            default: load_ext = rdata_shifted;
        endcase
    end

    // Access sequencing: latch the request in IDLE, wait for ready in REQ,
    // release the pipeline for one cycle in DONE
    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        be_d    = be_q;
        f3_d    = f3_q;
        off_d   = off_q;
        data_d  = data_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = REQ;
                    req_d   = 1'b1;
                    we_d    = MemWrite_M;
                    addr_d  = {ALUResult_M[ADDR_W-1:3], 3'b000};
                    wdata_d = WriteData_M << {off_eff, 3'b000};
                    be_d    = be_base << off_eff;
                    f3_d    = Funct3_M;
                    off_d   = off_eff;
                end
            end
            REQ: begin
                if (dmem.dmem_ready) begin
                    state_d = DONE;
                    req_d   = 1'b0;
                    if (!we_q) begin
                        data_d = load_ext;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and registered bus outputs, cleared by synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            be_q    <= '0;
            f3_q    <= '0;
            off_q   <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            be_q    <= be_d;
            f3_q    <= f3_d;
            off_q   <= off_d;
            data_q  <= data_d;
        end
    end

    assign dmem.dmem_req   = req_q;
    assign dmem.dmem_we    = we_q;
    assign dmem.dmem_addr  = addr_q;
    assign dmem.dmem_wdata = wdata_q;
    assign dmem.dmem_be    = be_q;
    assign ReadData_M      = data_q;

endmodule
